// File: rtl/fht_stream_ctrl_pkg.sv
// fht_stream_ctrl_pkg: shared defaults and FSM state encoding for the FHT
// streaming host front end (fht_stream_ctrl and fht_row_unpack).
package fht_stream_ctrl_pkg;

  localparam int IN_BIT_DEF = 15;  // ADC sample width (two's complement)
  localparam int D_BIT_DEF  = 16;  // core data width
  localparam int A_BIT_DEF  = 8;   // per-bank address width
  localparam int N_BANK_DEF = 4;   // bank count, power of two 2..16
  localparam int OVR_W      = 16;  // overrun counter width

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_START,
    ST_WAIT_LO,
    ST_WAIT_HI,
    ST_FETCH,
    ST_CAPT,
    ST_EMIT
  } state_t;

endpackage

// File: rtl/fht_row_unpack.sv
// fht_row_unpack: holds one RAM(A) row (N_BANK words) and serialises it onto
// the valid/ready output stream, word 0 first. Asserts o_row_done on the
// handshake of the final word so the controller can fetch the next row.
module fht_row_unpack
  import fht_stream_ctrl_pkg::*;
#(
  parameter int D_BIT  = D_BIT_DEF,
  parameter int N_BANK = N_BANK_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_capt,
  input  logic [N_BANK*D_BIT-1:0] i_row,
  input  logic                    i_last_row,
  input  logic                    i_out_ready,
  output logic                    o_out_valid,
  output logic [D_BIT-1:0]        o_out_data,
  output logic                    o_out_last,
  output logic                    o_row_done
);

  localparam int W_BIT = $clog2(N_BANK);

  logic [D_BIT-1:0] r_buf [N_BANK];
  logic [W_BIT-1:0] r_word;
  logic             r_valid;
  logic             w_fire;
  logic             w_last_word;

  assign w_fire      = r_valid && i_out_ready;
  assign w_last_word = (r_word == W_BIT'(N_BANK - 1));

  // Row capture, word index advance and valid tracking.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_word  <= '0;
      // NOTE: the buffer is only N_BANK registers, so it is reset to keep
      // o_out_data at zero out of reset; a real RAM would not be.
      for (int b = 0; b < N_BANK; b++) r_buf[b] <= '0;
    end else if (i_capt) begin
      for (int b = 0; b < N_BANK; b++) r_buf[b] <= i_row[b*D_BIT +: D_BIT];
      r_word  <= '0;
      r_valid <= 1'b1;
    end else if (w_fire) begin
      if (w_last_word) begin
        r_valid <= 1'b0;
        r_word  <= '0;
      end else begin
        r_word <= r_word + 1'b1;
      end
    end
  end

  // Outputs come straight from registers, so they hold while stalled.
  assign o_out_valid = r_valid;
  assign o_out_data  = r_valid ? r_buf[r_word] : '0;
  assign o_out_last  = r_valid && i_last_row && w_last_word;
  assign o_row_done  = w_fire && w_last_word;

endmodule

// File: rtl/fht_stream_ctrl.sv
// fht_stream_ctrl: streaming host front end for the FHT core. Loads a frame of
// N_BANK * 2**A_BIT samples into banked RAM(A), strobes the core, waits for
// completion and streams the results back out row by row.
// Optional build macro FHT_OVERRUN_CNT_EN adds oOVERRUN_CNT / oOVERRUN_LAST,
// counting cycles where a sample was offered while the block was busy.
module fht_stream_ctrl
  import fht_stream_ctrl_pkg::*;
#(
  parameter int IN_BIT = IN_BIT_DEF,
  parameter int D_BIT  = D_BIT_DEF,
  parameter int A_BIT  = A_BIT_DEF,
  parameter int N_BANK = N_BANK_DEF
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic                    iIN_VALID,
  input  logic [IN_BIT-1:0]       iIN_DATA,
  output logic                    oIN_READY,
  output logic [A_BIT-1:0]        oWR_ADDR,
  output logic [D_BIT-1:0]        oWR_DATA,
  output logic [N_BANK-1:0]       oWE,
  output logic [A_BIT-1:0]        oRD_ADDR,
  input  logic [N_BANK*D_BIT-1:0] iRD_DATA,
  output logic                    oSTART,
  input  logic                    iCORE_RDY,
  output logic                    oOUT_VALID,
  output logic [D_BIT-1:0]        oOUT_DATA,
  output logic                    oOUT_LAST,
  input  logic                    iOUT_READY,
`ifdef FHT_OVERRUN_CNT_EN
  output logic [OVR_W-1:0]        oOVERRUN_CNT,
  output logic [OVR_W-1:0]        oOVERRUN_LAST,
`endif
  output logic                    oBUSY
);

  localparam int LB    = $clog2(N_BANK);
  localparam int CNT_W = A_BIT + LB;

  state_t           r_state;
  logic [CNT_W-1:0] r_load_cnt;
  logic             r_start_cnt;
  logic [A_BIT-1:0] r_row;
  logic             w_in_fire;
  logic             w_last_row;
  logic             w_row_done;
  logic             w_enter_load;

  assign oIN_READY    = (r_state == ST_LOAD);
  assign oSTART       = (r_state == ST_START);
  assign oBUSY        = (r_state != ST_LOAD);
  assign oRD_ADDR     = r_row;
  assign w_in_fire    = iIN_VALID && oIN_READY;
  assign w_last_row   = (r_row == {A_BIT{1'b1}});
  assign w_enter_load = (r_state == ST_EMIT) && w_row_done && w_last_row;

  // Load path: sample n goes to bank n mod N_BANK at address n / N_BANK.
  assign oWE      = w_in_fire ? (N_BANK'(1) << r_load_cnt[LB-1:0]) : '0;
  assign oWR_ADDR = w_in_fire ? r_load_cnt[LB +: A_BIT] : '0;
  assign oWR_DATA = w_in_fire ? {{(D_BIT-IN_BIT){iIN_DATA[IN_BIT-1]}}, iIN_DATA} : '0;

  // Frame sequencing: load, strobe core, wait for its busy pulse, unload rows.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_state     <= ST_LOAD;
      r_load_cnt  <= '0;
      r_start_cnt <= 1'b0;
      r_row       <= '0;
    end else begin
      // NOTE: all state updates are non-blocking so every branch sees the
      // pre-edge values, independent of statement order.
      case (r_state)
        ST_LOAD: begin
          if (w_in_fire) begin
            r_load_cnt <= r_load_cnt + 1'b1;  // wraps to 0 after the last sample
            if (r_load_cnt == {CNT_W{1'b1}}) r_state <= ST_START;
          end
        end
        ST_START: begin
          // Two-cycle strobe so the half-rate core control always sees it.
          if (r_start_cnt) begin
            r_start_cnt <= 1'b0;
            r_state     <= ST_WAIT_LO;
          end else begin
            r_start_cnt <= 1'b1;
          end
        end
        ST_WAIT_LO: if (!iCORE_RDY) r_state <= ST_WAIT_HI;
        ST_WAIT_HI: begin
          if (iCORE_RDY) begin
            r_row   <= '0;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: r_state <= ST_CAPT;
        ST_CAPT:  r_state <= ST_EMIT;
        ST_EMIT: begin
          if (w_enter_load) begin
            r_row   <= '0;
            r_state <= ST_LOAD;
          end else if (w_row_done) begin
            r_row   <= r_row + 1'b1;
            r_state <= ST_FETCH;
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  fht_row_unpack #(
    .D_BIT  (D_BIT),
    .N_BANK (N_BANK)
  ) u_row_unpack (
    .i_clk       (iCLK),
    .i_rst_n     (iRESET),
    .i_capt      (r_state == ST_CAPT),
    .i_row       (iRD_DATA),
    .i_last_row  (w_last_row),
    .i_out_ready (iOUT_READY),
    .o_out_valid (oOUT_VALID),
    .o_out_data  (oOUT_DATA),
    .o_out_last  (oOUT_LAST),
    .o_row_done  (w_row_done)
  );

`ifdef FHT_OVERRUN_CNT_EN
  logic [OVR_W-1:0] r_ovr_cnt;
  logic [OVR_W-1:0] r_ovr_last;
  logic [OVR_W-1:0] w_ovr_next;

  // Saturating count of samples offered while not ready.
  always_comb begin
    // NOTE: default first so no path leaves w_ovr_next unassigned (no latch).
    w_ovr_next = r_ovr_cnt;
    if (iIN_VALID && !oIN_READY && (r_ovr_cnt != {OVR_W{1'b1}}))
      w_ovr_next = r_ovr_cnt + 1'b1;
  end

  // Snapshot the frame's count on return to LOAD, then restart from zero.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_ovr_cnt  <= '0;
      r_ovr_last <= '0;
    end else if (w_enter_load) begin
      r_ovr_last <= w_ovr_next;
      r_ovr_cnt  <= '0;
    end else begin
      r_ovr_cnt <= w_ovr_next;
    end
  end

  assign oOVERRUN_CNT  = r_ovr_cnt;
  assign oOVERRUN_LAST = r_ovr_last;
`endif

endmodule

// File: tb/tb_fht_stream_ctrl.sv
// tb_fht_stream_ctrl: randomized frames through fht_stream_ctrl with a banked
// RAM(A) model and an identity core model; every output word is compared with
// the sign-extended input sample of the same natural index.
module tb_fht_stream_ctrl;

  localparam int IN_BIT  = 15;
  localparam int D_BIT   = 16;
  localparam int A_BIT   = 3;
  localparam int N_BANK  = 4;
  localparam int N_POINT = N_BANK * (2 ** A_BIT);
  localparam int BUDGET  = 4000;

  logic                    iCLK = 1'b0;
  logic                    iRESET;
  logic                    iIN_VALID;
  logic [IN_BIT-1:0]       iIN_DATA;
  logic                    oIN_READY;
  logic [A_BIT-1:0]        oWR_ADDR;
  logic [D_BIT-1:0]        oWR_DATA;
  logic [N_BANK-1:0]       oWE;
  logic [A_BIT-1:0]        oRD_ADDR;
  logic [N_BANK*D_BIT-1:0] iRD_DATA;
  logic                    oSTART;
  logic                    iCORE_RDY;
  logic                    oOUT_VALID;
  logic [D_BIT-1:0]        oOUT_DATA;
  logic                    oOUT_LAST;
  logic                    iOUT_READY;
  logic                    oBUSY;
`ifdef FHT_OVERRUN_CNT_EN
  logic [15:0]             oOVERRUN_CNT;
  logic [15:0]             oOVERRUN_LAST;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int busy_cnt;

  logic [IN_BIT-1:0] samples [N_POINT];
  logic [D_BIT-1:0]  mem [N_BANK][2**A_BIT];
  logic [A_BIT-1:0]  rd_addr_q;

  always #5 iCLK = ~iCLK;

  fht_stream_ctrl #(
    .IN_BIT (IN_BIT),
    .D_BIT  (D_BIT),
    .A_BIT  (A_BIT),
    .N_BANK (N_BANK)
  ) dut (
    .iCLK          (iCLK),
    .iRESET        (iRESET),
    .iIN_VALID     (iIN_VALID),
    .iIN_DATA      (iIN_DATA),
    .oIN_READY     (oIN_READY),
    .oWR_ADDR      (oWR_ADDR),
    .oWR_DATA      (oWR_DATA),
    .oWE           (oWE),
    .oRD_ADDR      (oRD_ADDR),
    .iRD_DATA      (iRD_DATA),
    .oSTART        (oSTART),
    .iCORE_RDY     (iCORE_RDY),
    .oOUT_VALID    (oOUT_VALID),
    .oOUT_DATA     (oOUT_DATA),
    .oOUT_LAST     (oOUT_LAST),
    .iOUT_READY    (iOUT_READY),
`ifdef FHT_OVERRUN_CNT_EN
    .oOVERRUN_CNT  (oOVERRUN_CNT),
    .oOVERRUN_LAST (oOVERRUN_LAST),
`endif
    .oBUSY         (oBUSY)
  );

  // RAM(A) model: address sampled mid-cycle, data returned after one edge.
  always @(negedge iCLK) rd_addr_q <= oRD_ADDR;
  always @(posedge iCLK)
    for (int b = 0; b < N_BANK; b++) iRD_DATA[b*D_BIT +: D_BIT] <= mem[b][rd_addr_q];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Reference sign extension done arithmetically on the sample's value.
  function automatic logic [D_BIT-1:0] sext(input logic [IN_BIT-1:0] s);
    int v;
    v = int'(s);
    if (v >= 2 ** (IN_BIT - 1)) v = v - 2 ** IN_BIT;
    return D_BIT'(v);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, oIN_READY, 1);
    check({tag, "_we"},       oWE, 0);
    check({tag, "_wr"},       {oWR_ADDR, oWR_DATA}, 0);
    check({tag, "_start"},    oSTART, 0);
    check({tag, "_out"},      {oOUT_VALID, oOUT_LAST, oOUT_DATA}, 0);
    check({tag, "_rd_addr"},  oRD_ADDR, 0);
    check({tag, "_busy"},     oBUSY, 0);
  endtask

  task automatic load_frame(input bit ramp, input int gap_pct);
    int n   = 0;
    int cyc = 0;
    while (n < N_POINT && cyc < BUDGET) begin
      @(negedge iCLK);
      cyc++;
      iIN_DATA  = samples[n];
      iIN_VALID = ramp ? 1'b1 : ($urandom_range(99) >= gap_pct);
      #1;
      if (iIN_VALID && oIN_READY) begin
        check("wr_we",   oWE, 1 << (n % N_BANK));
        check("wr_addr", oWR_ADDR, n / N_BANK);
        check("wr_data", oWR_DATA, sext(samples[n]));
        if (ramp && n == 5)  check("ramp5", {oWE, 5'(oWR_ADDR)}, {4'b0010, 5'd1});
        if (ramp && n == 31) check("ramp31", {oWE, 5'(oWR_ADDR)}, {4'b1000, 5'd7});
        if (samples[n] == 15'h4000) check("sext_neg", oWR_DATA, 16'hC000);
        if (samples[n] == 15'h3FFF) check("sext_pos", oWR_DATA, 16'h3FFF);
        for (int b = 0; b < N_BANK; b++) if (oWE[b]) mem[b][oWR_ADDR] = oWR_DATA;
        n++;
      end else begin
        check("we_idle", oWE, 0);
      end
    end
    check("load_timeout", n, N_POINT);
  endtask

  // Start strobe and core handshake; input stays offered to exercise ignore.
  task automatic start_and_core(input int low_cycles);
    busy_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge iCLK);
      iIN_VALID = 1'b1;
      #1;
      busy_cnt++;
      check("start_strobe", oSTART, (i < 2) ? 1 : 0);
      check("busy_ready",   {oIN_READY, oWE}, 0);
    end
    // Core still reports ready: the controller must keep waiting.
    @(negedge iCLK);
    #1;
    busy_cnt++;
    check("wait_lo_hold", {oBUSY, oOUT_VALID}, 2'b10);
    iCORE_RDY = 1'b0;
    for (int i = 0; i < low_cycles; i++) begin
      @(negedge iCLK);
      busy_cnt++;
    end
    iCORE_RDY = 1'b1;
    @(negedge iCLK);
    #1;
    busy_cnt++;
    check("fetch_first", {oOUT_VALID, 8'(oRD_ADDR)}, 0);
    @(negedge iCLK);
    #1;
    busy_cnt++;
    check("capt_no_valid", oOUT_VALID, 0);
  endtask

  // Drain the frame; abort_at >= 0 pulls reset when that word is presented.
  task automatic unload(input int ready_pct, input int abort_at);
    int k   = 0;
    int cyc = 0;
    bit prev_stall = 0;
    while (k < N_POINT && cyc < BUDGET) begin
      @(negedge iCLK);
      cyc++;
      iOUT_READY = ($urandom_range(99) < ready_pct);
      #1;
      if (abort_at >= 0 && k == abort_at && oOUT_VALID) begin
        iIN_VALID = 1'b0;
        iRESET    = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge iCLK);
        iRESET = 1'b1;
        return;
      end
      busy_cnt++;
      if (cyc == 1)   check("first_valid", oOUT_VALID, 1);
      if (prev_stall) check("stall_hold", oOUT_VALID, 1);
      if (oOUT_VALID) begin
        check("out_data", oOUT_DATA, sext(samples[k]));
        check("out_last", oOUT_LAST, (k == N_POINT - 1) ? 1 : 0);
        if (iOUT_READY) k++;
      end
      prev_stall = oOUT_VALID && !iOUT_READY;
    end
    check("unload_timeout", k, N_POINT);
    @(negedge iCLK);
    iOUT_READY = 1'b0;
    #1;
    check("back_to_load", {oBUSY, oIN_READY}, 2'b01);
`ifdef FHT_OVERRUN_CNT_EN
    check("ovr_last", oOVERRUN_LAST, (busy_cnt > 65535) ? 65535 : busy_cnt);
    check("ovr_cleared", oOVERRUN_CNT, 0);
`endif
    iIN_VALID = 1'b0;
  endtask

  task automatic run_frame(input bit ramp, input int gap_pct, input int ready_pct,
                           input int low_cycles, input int abort_at);
    for (int i = 0; i < N_POINT; i++)
      samples[i] = ramp ? IN_BIT'(i) : IN_BIT'($urandom);
    if (!ramp) begin
      samples[0] = 15'h4000;
      samples[1] = 15'h3FFF;
    end
    load_frame(ramp, gap_pct);
    start_and_core(low_cycles);
    unload(ready_pct, abort_at);
  endtask

  initial begin
    for (int b = 0; b < N_BANK; b++)
      for (int a = 0; a < 2 ** A_BIT; a++) mem[b][a] = '0;
    iRESET     = 1'b0;
    iIN_VALID  = 1'b0;
    iIN_DATA   = '0;
    iCORE_RDY  = 1'b1;
    iOUT_READY = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (3) @(negedge iCLK);
    iRESET = 1'b1;

    run_frame(1'b1, 0,  100, 40, -1);   // ramp, no gaps, no backpressure
    run_frame(1'b0, 30, 50,  40, -1);   // random gaps and 50% backpressure
    run_frame(1'b0, 20, 60,  25, 10);   // reset while word 10 is presented
    run_frame(1'b0, 25, 50,  40, -1);   // full frame after the reset
`ifdef FHT_OVERRUN_CNT_EN
    run_frame(1'b0, 0,  100, 65600, -1); // busy long enough to saturate
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
